// File: rtl/mcpu6bit_memctl.sv
// Memory and clock companion for the 6-bit accumulator CPU.
// Generates the CPU clock (clk/4) and CPU reset, demultiplexes the shared
// address/data bus, holds the 16x6 RAM and provides a program-load port.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | CPU held in reset, waiting for prog_start or run
// LOAD  | program-load port open, one RAM word per prog_valid
// RUN   | CPU reset for RST_CYCLES CPU cycles, then released and counted
module mcpu6bit_memctl #(
   parameter int RST_CYCLES = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic             cpu_clk,
   output logic             cpu_rst_n,
   input  logic [5:0]       cpu_bus,
   input  logic             cpu_we_n,
   output logic [5:0]       cpu_din,
   input  logic             prog_start,
   input  logic             prog_valid,
   input  logic [5:0]       prog_data,
   output logic             prog_ready,
   input  logic             run,
   output logic             running,
   output logic [CNT_W-1:0] cyc_cnt
);

   localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t             state_q;
   logic [1:0]         ph_q;
   logic               cpu_clk_q;
   logic               cpu_rst_n_q;
   logic [5:0]         cpu_din_q;
   logic               prog_ready_q;
   logic               running_q;
   logic [CNT_W-1:0]   cyc_q;
   logic [3:0]         ptr_q;
   logic [3:0]         addr_q;
   logic [RCNT_W-1:0]  rcnt_q;
   // set when RUN was entered mid CPU cycle: that partial cycle is not counted
   logic               part_q;
   logic [5:0]         ram_q [16];

   logic               boundary;
   logic               load_wr;
   logic               cpu_wr;

   assign boundary = (ph_q == 2'd3);
   assign load_wr  = (state_q == S_LOAD) && !prog_start && prog_valid;
   assign cpu_wr   = boundary && (state_q == S_RUN) && cpu_rst_n_q && !cpu_we_n;

   assign cpu_clk    = cpu_clk_q;
   assign cpu_rst_n  = cpu_rst_n_q;
   assign cpu_din    = cpu_din_q;
   assign prog_ready = prog_ready_q;
   assign running    = running_q;
   assign cyc_cnt    = cyc_q;

   // RAM: load port has the only write path outside RUN, CPU writes in the low data phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) ram_q[i] <= 6'd0;
      end else if (load_wr) begin
         ram_q[ptr_q] <= prog_data;
      end else if (cpu_wr) begin
         ram_q[addr_q] <= cpu_bus;
      end
   end

   // Phase generator, bus demux and sequencing FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ph_q         <= 2'd0;
         cpu_clk_q    <= 1'b0;
         cpu_rst_n_q  <= 1'b0;
         cpu_din_q    <= 6'd0;
         prog_ready_q <= 1'b0;
         running_q    <= 1'b0;
         cyc_q        <= '0;
         ptr_q        <= 4'd0;
         addr_q       <= 4'd0;
         rcnt_q       <= '0;
         part_q       <= 1'b0;
      end else begin
         ph_q      <= ph_q + 2'd1;
         // high in the phases that follow ph3 and ph0
         cpu_clk_q <= (ph_q == 2'd3) || (ph_q == 2'd0);
         if (ph_q == 2'd1) addr_q <= cpu_bus[3:0];
         if (ph_q == 2'd2) cpu_din_q <= ram_q[addr_q];

         case (state_q)
            S_IDLE: begin
               if (prog_start) begin
                  state_q      <= S_LOAD;
                  ptr_q        <= 4'd0;
                  prog_ready_q <= 1'b1;
               end else if (run) begin
                  state_q <= S_RUN;
                  rcnt_q  <= '0;
                  part_q  <= !boundary;
                  cyc_q   <= '0;
               end
            end
            S_LOAD: begin
               if (prog_start) begin
                  ptr_q <= 4'd0;
               end else if (prog_valid) begin
                  ptr_q <= ptr_q + 4'd1;
                  if (ptr_q == 4'd15) begin
                     state_q      <= S_IDLE;
                     prog_ready_q <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (!run) begin
                  state_q     <= S_IDLE;
                  cpu_rst_n_q <= 1'b0;
                  running_q   <= 1'b0;
               end else if (boundary) begin
                  if (!cpu_rst_n_q) begin
                     if (part_q) begin
                        part_q <= 1'b0;
                     end else if (rcnt_q == RCNT_W'(RST_CYCLES - 1)) begin
                        cpu_rst_n_q <= 1'b1;
                        running_q   <= 1'b1;
                     end else begin
                        rcnt_q <= rcnt_q + RCNT_W'(1);
                     end
                  end else if (cyc_q != '1) begin
                     cyc_q <= cyc_q + CNT_W'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mcpu6bit_memctl.sv
// Bench for mcpu6bit_memctl: bus-model CPU cycles with a read-data scoreboard,
// plus a second instance with a 4-bit cycle counter for saturation.
module tb_mcpu6bit_memctl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] cpu_bus;
   logic       cpu_we_n;
   logic       prog_start, prog_valid, run;
   logic [5:0] prog_data;

   logic        cpu_clk, cpu_rst_n, prog_ready, running;
   logic [5:0]  cpu_din;
   logic [15:0] cyc_cnt;

   logic        cpu_clk2, cpu_rst_n2, prog_ready2, running2;
   logic [5:0]  cpu_din2;
   logic [3:0]  cyc_cnt2;

   int total = 0;
   int bad   = 0;

   logic [5:0] model_ram [16];
   logic [5:0] exp_q [$];
   logic [1:0] m_ph;

   mcpu6bit_memctl #(.RST_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
      .cpu_bus(cpu_bus), .cpu_we_n(cpu_we_n), .cpu_din(cpu_din),
      .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
      .prog_ready(prog_ready), .run(run), .running(running), .cyc_cnt(cyc_cnt)
   );

   mcpu6bit_memctl #(.RST_CYCLES(2), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst), .cpu_clk(cpu_clk2), .cpu_rst_n(cpu_rst_n2),
      .cpu_bus(cpu_bus), .cpu_we_n(cpu_we_n), .cpu_din(cpu_din2),
      .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
      .prog_ready(prog_ready2), .run(run), .running(running2), .cyc_cnt(cyc_cnt2)
   );

   always #5 clk = ~clk;

   // reference phase: ph counts every clk from 0 after reset
   always @(posedge clk or posedge rst) begin
      if (rst) m_ph <= 2'd0;
      else     m_ph <= m_ph + 2'd1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ph(input logic [1:0] p);
      int n = 0;
      while (m_ph !== p && n < 8) begin
         step();
         n++;
      end
      total++;
      if (n >= 8) begin
         bad++;
         $display("FAIL wait_ph got_steps=%0d want<8", n);
      end
   endtask

   // one CPU bus cycle starting at ph0: address high phase, data low phase
   task automatic cpu_cycle(input logic [3:0] a, input logic wr, input logic [5:0] d,
                            input logic takes);
      logic [5:0] want;
      wait_ph(2'd0);
      cpu_bus  = {2'b00, a};
      cpu_we_n = 1'b1;
      exp_q.push_back(model_ram[a]);
      if (wr && takes) model_ram[a] = d;
      step();
      step();
      cpu_bus  = d;
      cpu_we_n = !wr;
      step();
      step();
      cpu_we_n = 1'b1;
      want = exp_q.pop_front();
      total++;
      if (cpu_din !== want) begin
         bad++;
         $display("FAIL cpu_din addr=%0d got=%h want=%h", a, cpu_din, want);
      end
   endtask

   task automatic enter_run();
      wait_ph(2'd3);
      run = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_bus = 6'd0; cpu_we_n = 1'b1;
      prog_start = 1'b0; prog_valid = 1'b0; prog_data = 6'd0; run = 1'b0;
      for (int i = 0; i < 16; i++) model_ram[i] = 6'd0;
      step(); step();
      total++; if (cpu_clk !== 1'b0)   begin bad++; $display("FAIL rst_cpu_clk got=%b want=0", cpu_clk); end
      total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL rst_cpu_rst_n got=%b want=0", cpu_rst_n); end
      total++; if (cpu_din !== 6'd0)   begin bad++; $display("FAIL rst_cpu_din got=%h want=0", cpu_din); end
      total++; if (prog_ready !== 1'b0) begin bad++; $display("FAIL rst_prog_ready got=%b want=0", prog_ready); end
      total++; if (running !== 1'b0)   begin bad++; $display("FAIL rst_running got=%b want=0", running); end
      total++; if (cyc_cnt !== 16'd0)  begin bad++; $display("FAIL rst_cyc_cnt got=%0d want=0", cyc_cnt); end
      rst = 1'b0;
      step(); step();
      total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL idle_cpu_rst_n got=%b want=0", cpu_rst_n); end
   endtask

   task automatic test_load();
      total++; if (prog_ready !== 1'b0) begin bad++; $display("FAIL idle_prog_ready got=%b want=0", prog_ready); end
      prog_start = 1'b1;
      step();
      prog_start = 1'b0;
      total++; if (prog_ready !== 1'b1) begin bad++; $display("FAIL load_prog_ready got=%b want=1", prog_ready); end
      for (int i = 0; i < 16; i++) begin
         if (i % 3 == 1) begin
            prog_valid = 1'b0;
            step(); step();
         end
         prog_valid = 1'b1;
         prog_data  = 6'(i);
         step();
         model_ram[i] = 6'(i);
         if (i == 7) begin
            total++; if (prog_ready !== 1'b1) begin bad++; $display("FAIL load_mid_ready got=%b want=1", prog_ready); end
         end
      end
      prog_valid = 1'b0;
      total++; if (prog_ready !== 1'b0) begin bad++; $display("FAIL load_done_ready got=%b want=0", prog_ready); end
      prog_valid = 1'b1;
      prog_data  = 6'h3F;
      step();
      prog_valid = 1'b0;
      total++; if (prog_ready !== 1'b0) begin bad++; $display("FAIL load_17th_ready got=%b want=0", prog_ready); end
      for (int i = 0; i < 16; i++) cpu_cycle(4'(i), 1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_run_timing();
      enter_run();
      for (int k = 1; k <= 8; k++) begin
         step();
         total++;
         if (cpu_clk !== (m_ph < 2'd2)) begin
            bad++; $display("FAIL cpu_clk_phase ph=%0d got=%b want=%b", m_ph, cpu_clk, (m_ph < 2'd2));
         end
         if (k < 8) begin
            total++;
            if (cpu_rst_n !== 1'b0 || running !== 1'b0) begin
               bad++; $display("FAIL run_hold clk=%0d got=%b%b want=00", k, cpu_rst_n, running);
            end
         end
      end
      total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL run_release got=%b want=1", cpu_rst_n); end
      total++; if (running !== 1'b1)   begin bad++; $display("FAIL run_running got=%b want=1", running); end
      total++; if (cyc_cnt !== 16'd0)  begin bad++; $display("FAIL run_cnt0 got=%0d want=0", cyc_cnt); end
   endtask

   task automatic test_bus();
      cpu_cycle(4'd5, 1'b1, 6'h2A, 1'b1);
      cpu_cycle(4'd5, 1'b0, 6'h00, 1'b0);
      cpu_cycle(4'd9, 1'b1, 6'h15, 1'b1);
      cpu_cycle(4'd9, 1'b0, 6'h00, 1'b0);
      total++; if (cyc_cnt !== 16'd4) begin bad++; $display("FAIL bus_cnt got=%0d want=4", cyc_cnt); end
   endtask

   task automatic test_count();
      // fetch-style loop over addresses 0..3 with a periodic store to 12
      for (int i = 0; i < 96; i++) begin
         if (i % 8 == 7) cpu_cycle(4'd12, 1'b1, 6'(i), 1'b1);
         else            cpu_cycle(4'(i % 4), 1'b0, 6'd0, 1'b0);
      end
      total++; if (cyc_cnt !== 16'd100) begin bad++; $display("FAIL cnt_100 got=%0d want=100", cyc_cnt); end
      total++; if (cyc_cnt2 !== 4'd15)  begin bad++; $display("FAIL cnt_sat got=%0d want=15", cyc_cnt2); end
      run = 1'b0;
      step();
      total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL stop_rst_n got=%b want=0", cpu_rst_n); end
      total++; if (running !== 1'b0)   begin bad++; $display("FAIL stop_running got=%b want=0", running); end
      step(); step(); step(); step(); step();
      total++; if (cyc_cnt !== 16'd100) begin bad++; $display("FAIL stop_hold got=%0d want=100", cyc_cnt); end
      cpu_cycle(4'd12, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_no_write();
      cpu_cycle(4'd3, 1'b1, 6'h3F, 1'b0);
      enter_run();
      cpu_cycle(4'd3, 1'b1, 6'h3F, 1'b0);
      cpu_cycle(4'd4, 1'b1, 6'h3E, 1'b0);
      total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL nw_release got=%b want=1", cpu_rst_n); end
      cpu_cycle(4'd3, 1'b0, 6'd0, 1'b0);
      cpu_cycle(4'd4, 1'b0, 6'd0, 1'b0);
      total++; if (cyc_cnt !== 16'd2) begin bad++; $display("FAIL nw_cnt got=%0d want=2", cyc_cnt); end
      run = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_run();
      enter_run();
      for (int k = 0; k < 12; k++) step();
      wait_ph(2'd2);
      rst = 1'b1;
      #1;
      total++; if (cpu_clk !== 1'b0)    begin bad++; $display("FAIL mid_cpu_clk got=%b want=0", cpu_clk); end
      total++; if (cpu_rst_n !== 1'b0)  begin bad++; $display("FAIL mid_rst_n got=%b want=0", cpu_rst_n); end
      total++; if (cpu_din !== 6'd0)    begin bad++; $display("FAIL mid_cpu_din got=%h want=0", cpu_din); end
      total++; if (prog_ready !== 1'b0) begin bad++; $display("FAIL mid_prog_ready got=%b want=0", prog_ready); end
      total++; if (running !== 1'b0)    begin bad++; $display("FAIL mid_running got=%b want=0", running); end
      total++; if (cyc_cnt !== 16'd0)   begin bad++; $display("FAIL mid_cyc_cnt got=%0d want=0", cyc_cnt); end
      run = 1'b0;
      cpu_we_n = 1'b1;
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) model_ram[i] = 6'd0;
      for (int i = 0; i < 16; i++) cpu_cycle(4'(i), 1'b0, 6'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_load();
      test_run_timing();
      test_bus();
      test_count();
      test_no_write();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
